// File: rtl/execution_stage_md.sv
// Execution stage: operand forwarding muxes, the base ALU, an iterative RV32M
// multiply/divide unit and the EX/MEM pipeline register.
//
// ALU_INSTRUCTION encoding:
//   0 ADD  1 SUB  2 SLL  3 SLT  4 SLTU  5 XOR  6 SRL  7 SRA  8 OR  9 AND
//   10 BEQ 11 BNE 12 BLT 13 BGE 14 BLTU 15 BGEU (branch flag only, alu_out = 0)
//   any other value: alu_out = 0, no branch
module execution_stage_md #(
  parameter int unsigned NUM_FWD = 4,
  parameter logic        HIGH    = 1'b1,
  parameter logic        LOW     = 1'b0,
  localparam int unsigned SEL_W  = $clog2(NUM_FWD + 2)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   STALL_IN,
  input  logic                   CLEAR_IN,
  input  logic                   VALID_IN,
  input  logic [31:0]            PC_IN,
  input  logic [31:0]            RS1_DATA,
  input  logic [31:0]            RS2_DATA,
  input  logic [31:0]            IMM_DATA,
  input  logic [32*NUM_FWD-1:0]  RS1_FWD_DATA,
  input  logic [32*NUM_FWD-1:0]  RS2_FWD_DATA,
  input  logic [SEL_W-1:0]       IN1_SELECT,
  input  logic [SEL_W-1:0]       IN2_SELECT,
  input  logic [4:0]             ALU_INSTRUCTION,
  input  logic                   MD_EN,
  input  logic [2:0]             MD_OP,
  input  logic [4:0]             RD_ADDRESS_IN,
  input  logic [2:0]             DATA_CACHE_LOAD_IN,
  input  logic [1:0]             DATA_CACHE_STORE_IN,
  input  logic [31:0]            DATA_CACHE_STORE_DATA_IN,
  input  logic                   WRITE_BACK_MUX_SELECT_IN,
  input  logic                   RD_WRITE_ENABLE_IN,
  output logic                   MD_BUSY,
  output logic                   BRANCH_TAKEN,
  output logic                   VALID_OUT,
  output logic [31:0]            RESULT_OUT,
  output logic [4:0]             RD_ADDRESS_OUT,
  output logic [2:0]             DATA_CACHE_LOAD_OUT,
  output logic [1:0]             DATA_CACHE_STORE_OUT,
  output logic [31:0]            DATA_CACHE_STORE_DATA_OUT,
  output logic                   WRITE_BACK_MUX_SELECT_OUT,
  output logic                   RD_WRITE_ENABLE_OUT
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  logic stall, clear, valid_in, md_en;
  assign stall    = (STALL_IN == HIGH);
  assign clear    = (CLEAR_IN == HIGH);
  assign valid_in = (VALID_IN == HIGH);
  assign md_en    = (MD_EN == HIGH);

  logic [31:0] in1, in2;

  // Operand muxes; selects past the last forwarding slice give zero.
  always_comb begin
    in1 = '0;
    in2 = '0;
    if (32'(IN1_SELECT) == 32'd0) in1 = RS1_DATA;
    if (32'(IN1_SELECT) == 32'd1) in1 = PC_IN;
    if (32'(IN2_SELECT) == 32'd0) in2 = RS2_DATA;
    if (32'(IN2_SELECT) == 32'd1) in2 = IMM_DATA;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (32'(IN1_SELECT) == k + 2) in1 = RS1_FWD_DATA[32*k +: 32];
      if (32'(IN2_SELECT) == k + 2) in2 = RS2_FWD_DATA[32*k +: 32];
    end
  end

  logic [31:0] alu_out;
  logic        alu_branch;

  // Base ALU and branch comparator.
  always_comb begin
    alu_out    = '0;
    alu_branch = 1'b0;
    case (ALU_INSTRUCTION)
      5'd0:  alu_out = in1 + in2;
      5'd1:  alu_out = in1 - in2;
      5'd2:  alu_out = in1 << in2[4:0];
      5'd3:  alu_out = {31'b0, ($signed(in1) < $signed(in2))};
      5'd4:  alu_out = {31'b0, (in1 < in2)};
      5'd5:  alu_out = in1 ^ in2;
      5'd6:  alu_out = in1 >> in2[4:0];
      5'd7:  alu_out = $signed(in1) >>> in2[4:0];
      5'd8:  alu_out = in1 | in2;
      5'd9:  alu_out = in1 & in2;
      5'd10: alu_branch = (in1 == in2);
      5'd11: alu_branch = (in1 != in2);
      5'd12: alu_branch = ($signed(in1) < $signed(in2));
      5'd13: alu_branch = ($signed(in1) >= $signed(in2));
      5'd14: alu_branch = (in1 < in2);
      5'd15: alu_branch = (in1 >= in2);
      default: ;
    endcase
  end

  assign BRANCH_TAKEN = (alu_branch && valid_in && !md_en) ? HIGH : LOW;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]  md_op_q, md_op_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d;

  logic accept, md_busy;
  assign accept  = (state_q == StIdle) && valid_in && md_en && !stall && !clear;
  assign md_busy = accept || (state_q == StMul) || (state_q == StDiv);
  assign MD_BUSY = md_busy ? HIGH : LOW;

  // Multiplier operands are extended to 64 bits so one unsigned product
  // covers all four signedness combinations.
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = {{32{(md_op_q[1:0] != 2'b11) & op_a_q[31]}}, op_a_q};
  assign mul_b   = {{32{!md_op_q[1] & op_b_q[31]}}, op_b_q};
  assign product = mul_a * mul_b;

  // Restoring divider step on magnitudes; quo_q shifts the dividend out
  // while quotient bits shift in.
  logic        a_neg, b_neg, fits;
  logic [31:0] divisor_mag;
  logic [32:0] shifted;
  logic [33:0] diff;
  assign a_neg       = !md_op_q[0] & op_a_q[31];
  assign b_neg       = !md_op_q[0] & op_b_q[31];
  assign divisor_mag = b_neg ? -op_b_q : op_b_q;
  assign shifted     = {rem_q, quo_q[31]};
  assign diff        = {1'b0, shifted} - {2'b00, divisor_mag};
  // Partial remainder stays below the divisor, so any bit above 31 means negative.
  assign fits        = (diff[33:32] == 2'b00);

  logic [31:0] md_result;

  // Result selection and sign fix-up, valid while in StDone.
  always_comb begin
    md_result = '0;
    if (!md_op_q[2]) begin
      md_result = (md_op_q[1:0] == 2'b00) ? prod_q[31:0] : prod_q[63:32];
    end else if (op_b_q == '0) begin
      md_result = md_op_q[1] ? op_a_q : '1;
    end else if (md_op_q[1]) begin
      md_result = a_neg ? -rem_q : rem_q;
    end else begin
      md_result = (a_neg ^ b_neg) ? -quo_q : quo_q;
    end
  end

  // Multiply/divide FSM next state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    md_op_d = md_op_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_a_d  = in1;
          op_b_d  = in2;
          md_op_d = MD_OP;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (!MD_OP[0] && in1[31]) ? -in1 : in1;
          state_d = MD_OP[2] ? StDiv : StMul;
        end
      end
      StMul: begin
        if (!stall) begin
          if (clear) begin
            state_d = StIdle;
          end else begin
            prod_d  = product;
            state_d = StDone;
          end
        end
      end
      StDiv: begin
        if (!stall) begin
          if (clear) begin
            state_d = StIdle;
          end else begin
            quo_d = {quo_q[30:0], fits};
            rem_d = fits ? diff[31:0] : shifted[31:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and multiply/divide datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      md_op_q <= '0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      md_op_q <= md_op_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  // EX/MEM register: stall holds, clear zeroes, busy inserts a bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALID_OUT                 <= LOW;
      RESULT_OUT                <= '0;
      RD_ADDRESS_OUT            <= '0;
      DATA_CACHE_LOAD_OUT       <= '0;
      DATA_CACHE_STORE_OUT      <= '0;
      DATA_CACHE_STORE_DATA_OUT <= '0;
      WRITE_BACK_MUX_SELECT_OUT <= LOW;
      RD_WRITE_ENABLE_OUT       <= LOW;
    end else if (!stall) begin
      if (clear) begin
        VALID_OUT                 <= LOW;
        RESULT_OUT                <= '0;
        RD_ADDRESS_OUT            <= '0;
        DATA_CACHE_LOAD_OUT       <= '0;
        DATA_CACHE_STORE_OUT      <= '0;
        DATA_CACHE_STORE_DATA_OUT <= '0;
        WRITE_BACK_MUX_SELECT_OUT <= LOW;
        RD_WRITE_ENABLE_OUT       <= LOW;
      end else if (md_busy) begin
        VALID_OUT            <= LOW;
        RD_WRITE_ENABLE_OUT  <= LOW;
        DATA_CACHE_STORE_OUT <= '0;
      end else begin
        VALID_OUT                 <= VALID_IN;
        RESULT_OUT                <= (state_q == StDone) ? md_result : alu_out;
        RD_ADDRESS_OUT            <= RD_ADDRESS_IN;
        DATA_CACHE_LOAD_OUT       <= DATA_CACHE_LOAD_IN;
        DATA_CACHE_STORE_OUT      <= DATA_CACHE_STORE_IN;
        DATA_CACHE_STORE_DATA_OUT <= DATA_CACHE_STORE_DATA_IN;
        WRITE_BACK_MUX_SELECT_OUT <= WRITE_BACK_MUX_SELECT_IN;
        RD_WRITE_ENABLE_OUT       <= RD_WRITE_ENABLE_IN;
      end
    end
  end

endmodule

// File: tb/tb_execution_stage_md.sv
// Self-checking bench for execution_stage_md: directed corner cases followed
// by randomized traffic, all checked against a transaction-level model.
module tb_execution_stage_md;

  localparam int unsigned NUM_FWD = 4;
  localparam int unsigned SEL_W   = $clog2(NUM_FWD + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Stimulus
  logic              stall, clear, valid, md_en;
  logic [2:0]        md_op;
  logic [31:0]       pc, rs1, rs2, imm;
  logic [31:0]       fwd1 [NUM_FWD];
  logic [31:0]       fwd2 [NUM_FWD];
  logic [32*NUM_FWD-1:0] fwd1_bus, fwd2_bus;
  logic [SEL_W-1:0]  sel1, sel2;
  logic [4:0]        alu_op, rd;
  logic [2:0]        ld;
  logic [1:0]        st;
  logic [31:0]       sdata;
  logic              wbsel, rdwe;

  // DUT outputs
  logic        md_busy_o, branch_o, valid_o, wbsel_o, rdwe_o;
  logic [31:0] result_o, sdata_o;
  logic [4:0]  rd_o;
  logic [2:0]  ld_o;
  logic [1:0]  st_o;

  always_comb begin
    fwd1_bus = '0;
    fwd2_bus = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd1_bus[32*k +: 32] = fwd1[k];
      fwd2_bus[32*k +: 32] = fwd2[k];
    end
  end

  execution_stage_md #(.NUM_FWD(NUM_FWD)) dut (
    .CLK                       (clk),
    .RST_N                     (rst_n),
    .STALL_IN                  (stall),
    .CLEAR_IN                  (clear),
    .VALID_IN                  (valid),
    .PC_IN                     (pc),
    .RS1_DATA                  (rs1),
    .RS2_DATA                  (rs2),
    .IMM_DATA                  (imm),
    .RS1_FWD_DATA              (fwd1_bus),
    .RS2_FWD_DATA              (fwd2_bus),
    .IN1_SELECT                (sel1),
    .IN2_SELECT                (sel2),
    .ALU_INSTRUCTION           (alu_op),
    .MD_EN                     (md_en),
    .MD_OP                     (md_op),
    .RD_ADDRESS_IN             (rd),
    .DATA_CACHE_LOAD_IN        (ld),
    .DATA_CACHE_STORE_IN       (st),
    .DATA_CACHE_STORE_DATA_IN  (sdata),
    .WRITE_BACK_MUX_SELECT_IN  (wbsel),
    .RD_WRITE_ENABLE_IN        (rdwe),
    .MD_BUSY                   (md_busy_o),
    .BRANCH_TAKEN              (branch_o),
    .VALID_OUT                 (valid_o),
    .RESULT_OUT                (result_o),
    .RD_ADDRESS_OUT            (rd_o),
    .DATA_CACHE_LOAD_OUT       (ld_o),
    .DATA_CACHE_STORE_OUT      (st_o),
    .DATA_CACHE_STORE_DATA_OUT (sdata_o),
    .WRITE_BACK_MUX_SELECT_OUT (wbsel_o),
    .RD_WRITE_ENABLE_OUT       (rdwe_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid, m_wbsel, m_rdwe, m_dc;
  logic [31:0] m_result, m_sdata;
  logic [4:0]  m_rd;
  logic [2:0]  m_ld;
  logic [1:0]  m_st;
  logic        m_active;   // an MD operation is in flight
  int          m_wait;     // edges left before its result is ready
  logic [31:0] m_res;

  function automatic logic [31:0] pick(input logic [SEL_W-1:0] sel, input logic [31:0] d0,
                                       input logic [31:0] d1, input bit second);
    int unsigned s = 32'(sel);
    if (s == 0) return d0;
    if (s == 1) return d1;
    if (s < NUM_FWD + 2) return second ? fwd2[s-2] : fwd1[s-2];
    return 32'd0;
  endfunction

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a << b[4:0];
      5'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4: return (a < b) ? 32'd1 : 32'd0;
      5'd5: return a ^ b;
      5'd6: return a >> b[4:0];
      5'd7: return $signed(a) >>> b[4:0];
      5'd8: return a | b;
      5'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit branch_model(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      5'd10: return a == b;
      5'd11: return a != b;
      5'd12: return $signed(a) < $signed(b);
      5'd13: return $signed(a) >= $signed(b);
      5'd14: return a < b;
      5'd15: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    longint          q;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_rd = 0; m_ld = 0; m_st = 0; m_sdata = 0;
    m_wbsel = 0; m_rdwe = 0; m_dc = 0; m_active = 0; m_wait = 0; m_res = 0;
  endtask

  task automatic model_comb(output logic busy, output logic br);
    logic [31:0] a = pick(sel1, rs1, pc, 1'b0);
    logic [31:0] b = pick(sel2, rs2, imm, 1'b1);
    logic accept = !m_active && valid && md_en && !stall && !clear;
    busy = accept || (m_active && m_wait > 0);
    br   = branch_model(alu_op, a, b) && valid && !md_en;
  endtask

  task automatic model_edge();
    logic busy, br;
    logic [31:0] a = pick(sel1, rs1, pc, 1'b0);
    logic [31:0] b = pick(sel2, rs2, imm, 1'b1);
    model_comb(busy, br);
    if (!stall) begin
      if (clear) begin
        m_valid = 0; m_result = 0; m_rd = 0; m_ld = 0; m_st = 0; m_sdata = 0;
        m_wbsel = 0; m_rdwe = 0; m_dc = 0;
      end else if (busy) begin
        m_valid = 0; m_rdwe = 0; m_st = 0; m_dc = 1;
      end else begin
        m_valid  = valid;
        m_result = (m_active && m_wait == 0) ? m_res : alu_model(alu_op, a, b);
        m_rd = rd; m_ld = ld; m_st = st; m_sdata = sdata; m_wbsel = wbsel; m_rdwe = rdwe;
        m_dc = 0;
      end
      if (!m_active) begin
        if (valid && md_en && !clear) begin
          m_active = 1;
          m_wait   = md_op[2] ? 32 : 1;
          m_res    = md_model(md_op, a, b);
        end
      end else if (clear || m_wait == 0) begin
        m_active = 0;
      end else begin
        m_wait--;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid_out", valid_o, m_valid);
    check_eq("rd_write_enable_out", rdwe_o, m_rdwe);
    check_eq("store_out", st_o, m_st);
    if (!m_dc) begin
      check_eq("result_out", result_o, m_result);
      check_eq("rd_address_out", rd_o, m_rd);
      check_eq("load_out", ld_o, m_ld);
      check_eq("store_data_out", sdata_o, m_sdata);
      check_eq("wb_mux_select_out", wbsel_o, m_wbsel);
    end
  endtask

  // One clock: check combinational outputs, take the edge, check registers.
  task automatic step(output logic busy_seen);
    logic eb, ebr;
    #2;
    model_comb(eb, ebr);
    busy_seen = md_busy_o;
    check_eq("md_busy", md_busy_o, eb);
    check_eq("branch_taken", branch_o, ebr);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_instr();
    valid  = ($urandom_range(0, 7) != 0);
    md_en  = ($urandom_range(0, 2) == 0);
    md_op  = 3'($urandom);
    pc = rand_word(); rs1 = rand_word(); rs2 = rand_word(); imm = rand_word();
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd1[k] = rand_word();
      fwd2[k] = rand_word();
    end
    sel1   = SEL_W'($urandom);
    sel2   = SEL_W'($urandom);
    alu_op = 5'($urandom_range(0, 17));
    rd = 5'($urandom); ld = 3'($urandom); st = 2'($urandom); sdata = $urandom;
    wbsel = 1'($urandom); rdwe = 1'($urandom);
  endtask

  task automatic set_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    randomize_instr();
    valid = 1; md_en = 1; md_op = op; sel1 = '0; sel2 = '0; rs1 = a; rs2 = b;
    stall = 0; clear = 0;
  endtask

  task automatic idle_instr();
    valid = 0; md_en = 0; stall = 0; clear = 0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_busy);
    logic bs;
    int   busy_n = 0;
    bit   done   = 0;
    set_md(op, a, b);
    for (int i = 0; i < 60 && !done; i++) begin
      step(bs);
      if (bs) busy_n++;
      else done = 1;
    end
    check_eq({tag, "_completed"}, done, 1);
    check_eq({tag, "_busy_cycles"}, busy_n, exp_busy);
    check_eq({tag, "_result"}, result_o, exp_res);
    check_eq({tag, "_valid"}, valid_o, 1);
    idle_instr();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic bs, br, hold;
    rst_n = 0;
    randomize_instr();
    idle_instr();
    model_reset();
    #3;
    check_outputs();
    model_comb(bs, br);
    check_eq("reset_md_busy", md_busy_o, bs);
    @(posedge clk);
    #1;
    rst_n = 1;

    // ADD through forwarding slice 0, then an out-of-range select.
    randomize_instr();
    valid = 1; md_en = 0; alu_op = 5'd0; sel1 = SEL_W'(2); fwd1[0] = 32'd5;
    sel2 = '0; rs2 = 32'd7; stall = 0; clear = 0;
    step(bs);
    check_eq("add_fwd_result", result_o, 32'd12);
    check_eq("add_fwd_valid", valid_o, 1);
    sel1 = SEL_W'(NUM_FWD + 2);
    step(bs);
    check_eq("add_sel_oob_result", result_o, 32'd7);
    idle_instr();
    step(bs);

    run_md("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_md("div_neg", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_md("rem_neg", 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_md("divu_by_zero", 3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 33);
    run_md("rem_by_zero", 3'b110, 32'h8765_4321, 32'd0, 32'h8765_4321, 33);
    run_md("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_md("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // MUL -7 x 3 with a four-cycle stall while the result waits in DONE.
    set_md(3'b000, 32'hFFFF_FFF9, 32'd3);
    step(bs);
    step(bs);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      step(bs);
      check_eq("stall_done_valid", valid_o, 0);
      check_eq("stall_done_busy", bs, 0);
    end
    stall = 0;
    step(bs);
    check_eq("stall_release_result", result_o, 32'hFFFF_FFEB);
    check_eq("stall_release_valid", valid_o, 1);
    idle_instr();
    step(bs);

    // Clear during the divide loop aborts without writing.
    set_md(3'b100, 32'd1000, 32'd7);
    for (int i = 0; i < 11; i++) step(bs);
    clear = 1;
    step(bs);
    check_eq("clear_div_valid", valid_o, 0);
    check_eq("clear_div_result", result_o, 0);
    idle_instr();
    step(bs);
    check_eq("clear_div_idle_busy", bs, 0);
    check_eq("clear_div_no_write", valid_o, 0);

    // Asynchronous reset mid-divide, then a fresh DIVU.
    set_md(3'b100, 32'hFFFF_FFEC, 32'd3);
    for (int i = 0; i < 21; i++) step(bs);
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_mid_result", result_o, 0);
    check_eq("rst_mid_valid", valid_o, 0);
    model_comb(bs, br);
    check_eq("rst_mid_busy", md_busy_o, bs);
    rst_n = 1;
    run_md("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    step(bs);

    // Randomized traffic; upstream holds its instruction while busy or stalled.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!hold) randomize_instr();
      stall = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 39) == 0);
      step(bs);
      hold = bs || stall;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execution_stage_md.md
EXECUTION_STAGE_MD -- requirements
Module: EXECUTION_STAGE_MD

Interface
REQ-001 Parameter NUM_FWD, default 4, range 1..6: forwarding sources per operand. SEL_W = clog2(NUM_FWD+2).
REQ-002 Parameter HIGH/LOW, default 1'b1/1'b0: active levels of STALL_IN, CLEAR_IN, VALID_IN, MD_EN and all 1-bit outputs.
REQ-003 Ports, one per line: name, direction, width, meaning.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- STALL_IN  in  1  hold EX/MEM register and FSM.
- CLEAR_IN  in  1  flush EX/MEM register and abort MD operation.
- VALID_IN  in  1  instruction present.
- PC_IN, RS1_DATA, RS2_DATA, IMM_DATA  in  32 each  operand sources.
- RS1_FWD_DATA, RS2_FWD_DATA  in  32*NUM_FWD each  flat forwarding buses; slice k = source k, k=0 nearest.
- IN1_SELECT, IN2_SELECT  in  SEL_W each  operand mux selects.
- ALU_INSTRUCTION  in  5  existing ALU opcode.
- MD_EN  in  1  RV32M instruction.
- MD_OP  in  3  RV32M funct3.
- RD_ADDRESS_IN  in  5  destination register.
- DATA_CACHE_LOAD_IN  in  3  pass-through.
- DATA_CACHE_STORE_IN  in  2  pass-through.
- DATA_CACHE_STORE_DATA_IN  in  32  pass-through.
- WRITE_BACK_MUX_SELECT_IN, RD_WRITE_ENABLE_IN  in  1 each  pass-through.
- MD_BUSY  out  1  combinational stall request to upstream.
- BRANCH_TAKEN  out  1  combinational.
- VALID_OUT  out  1  registered.
- RESULT_OUT  out  32  registered.
- Registered outputs for RD_ADDRESS, DATA_CACHE_LOAD, DATA_CACHE_STORE, DATA_CACHE_STORE_DATA, WRITE_BACK_MUX_SELECT and RD_WRITE_ENABLE, each named with suffix _OUT.

Function
REQ-004 Operand muxes:
- IN1_SELECT 0 = RS1_DATA, 1 = PC_IN; IN2_SELECT 0 = RS2_DATA, 1 = IMM_DATA.
- Select s in 2..NUM_FWD+1 = forwarding slice s-2.
- Any other select value yields 0.
REQ-005 The existing ALU computes alu_out combinationally. BRANCH_TAKEN = ALU branch output AND VALID_IN AND NOT MD_EN.
REQ-006 FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE.
REQ-007 Accept condition: IDLE, VALID_IN, MD_EN, STALL_IN and CLEAR_IN all low. On accept, capture both operands and MD_OP, then go to MUL if MD_OP[2]=0, else DIV.
REQ-008 MUL state:
- One cycle: register the 64-bit product (signed/unsigned per MUL/MULH/MULHSU/MULHU), then go to DONE.
- MUL selects low word; the others select high word.
REQ-009 DIV state:
- Restoring radix-2 on operand magnitudes, 6-bit counter, 32 iterations, then DONE.
- Sign fix-up is applied in DONE: quotient sign = sign XOR; remainder sign = dividend sign.
REQ-010 Boundary results:
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0.
REQ-011 MD_BUSY = (IDLE AND accept condition) OR MUL OR DIV. MD_BUSY is low in DONE, so upstream advances on the edge that loads the result.
REQ-012 DONE with STALL_IN low: load the EX/MEM register with the MD result and pass-through fields, then go to IDLE. DONE with STALL_IN high: remain in DONE.
REQ-013 EX/MEM register update, in priority order:
1. STALL_IN high: hold.
2. CLEAR_IN high: all outputs 0.
3. MD_BUSY high: bubble; VALID_OUT=0, RD_WRITE_ENABLE_OUT=0, DATA_CACHE_STORE_OUT=0, other fields don't-care.
4. Otherwise load alu_out (or MD result in DONE) and pass-through fields; VALID_OUT = VALID_IN.
REQ-014 CLEAR_IN high in MUL, DIV or DONE (STALL_IN low) returns the FSM to IDLE on that edge; no result is written.
REQ-015 Latency:
- Non-MD instruction: 1 edge.
- MUL family: result loaded on the 3rd edge after the accept cycle begins; MD_BUSY high 2 cycles.
- DIV family: loaded on the 34th edge; MD_BUSY high 33 cycles.

Reset
REQ-016 RST_N low asynchronously forces FSM to IDLE, counter 0, captured operands 0, and all registered outputs 0. MD_BUSY then follows REQ-011.
REQ-017 Reset asserted mid-operation discards the operation; the first accept after release starts a fresh operation.

Verification
REQ-018 ADD with IN1_SELECT=2, slice0=5, RS2=7 -> RESULT_OUT=12, VALID_OUT=1 after 1 edge; select NUM_FWD+2 -> operand 0.
REQ-019 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> MD_BUSY high 2 cycles, RESULT_OUT=0xFFFFFFFE; MUL -7 x 3 -> 0xFFFFFFEB.
REQ-020 DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; MD_BUSY high exactly 33 cycles.
REQ-021 DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000 by 0xFFFFFFFF -> 0.
REQ-022 STALL_IN held 4 cycles in DONE -> outputs frozen, result loaded on first unstalled edge. CLEAR_IN at DIV iteration 10 -> IDLE, no write.
REQ-023 RST_N low at DIV iteration 20 -> all outputs 0 immediately; next DIVU 100/7 -> 14.
